// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core's rename/register-file slice.
package ooo_pkg;

  localparam int unsigned RF_RW     = 5;
  localparam int unsigned ROB_TAG_W = 3;
  localparam int unsigned REG_ZERO  = 0;

  typedef logic [RF_RW-1:0]     rf_idx_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DONE
  } rf_flush_e;

endpackage

// File: rtl/rf_commit_merge.sv
// Resolves the commit ports into per-register write enable, data and tag match;
// a higher port index overrides lower ones targeting the same register.
module rf_commit_merge
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 3,
  parameter int unsigned NUM_COMMIT = 2,
  parameter int unsigned RW         = $clog2(NUM_REGS)
) (
  input  logic [NUM_COMMIT-1:0]       cm_valid,
  input  logic [NUM_COMMIT*RW-1:0]    cm_rd,
  input  logic [NUM_COMMIT*TAG_W-1:0] cm_tag,
  input  logic [NUM_COMMIT*XLEN-1:0]  cm_data,
  input  logic [TAG_W-1:0]            tags     [NUM_REGS],
  output logic [NUM_REGS-1:0]         we,
  output logic [XLEN-1:0]             wdata    [NUM_REGS],
  output logic [NUM_REGS-1:0]         tag_match
);

  always_comb begin
    we        = '0;
    tag_match = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wdata[r] = '0;
      for (int unsigned p = 0; p < NUM_COMMIT; p++) begin
        if (cm_valid[p] && (cm_rd[p*RW +: RW] == RW'(r))) begin
          we[r]        = 1'b1;
          wdata[r]     = cm_data[p*XLEN +: XLEN];
          tag_match[r] = (cm_tag[p*TAG_W +: TAG_W] == tags[r]);
        end
      end
    end
    we[REG_ZERO]        = 1'b0;
    tag_match[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file with rename status (valid + youngest producer tag),
// commit bypass on reads and a flush handshake that marks every register valid.
module regfile_rat
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 3,
  parameter int unsigned NUM_READ   = 3,
  parameter int unsigned NUM_COMMIT = 2,
  parameter int unsigned RW         = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic [RW-1:0]               alloc_rd,
  input  logic [TAG_W-1:0]            alloc_tag,
  output logic                        alloc_ready,
  input  logic [NUM_COMMIT-1:0]       cm_valid,
  input  logic [NUM_COMMIT*RW-1:0]    cm_rd,
  input  logic [NUM_COMMIT*TAG_W-1:0] cm_tag,
  input  logic [NUM_COMMIT*XLEN-1:0]  cm_data,
  input  logic [NUM_READ*RW-1:0]      rd_addr,
  output logic [NUM_READ*XLEN-1:0]    rd_data,
  output logic [NUM_READ-1:0]         rd_valid,
  output logic [NUM_READ*TAG_W-1:0]   rd_tag,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [RW:0]                 pending_cnt
);

  logic [XLEN-1:0]     data_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_q   [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q;
  rf_flush_e           state;

  logic [NUM_REGS-1:0] cm_we;
  logic [NUM_REGS-1:0] cm_match;
  logic [XLEN-1:0]     cm_wdata [NUM_REGS];
  logic                alloc_fire;

  rf_commit_merge #(
    .NUM_REGS  (NUM_REGS),
    .XLEN      (XLEN),
    .TAG_W     (TAG_W),
    .NUM_COMMIT(NUM_COMMIT),
    .RW        (RW)
  ) u_merge (
    .cm_valid (cm_valid),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_data  (cm_data),
    .tags     (tag_q),
    .we       (cm_we),
    .wdata    (cm_wdata),
    .tag_match(cm_match)
  );

  assign alloc_fire = alloc_valid && alloc_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      alloc_ready <= 1'b1;
      flush_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state       <= FLUSH;
            alloc_ready <= 1'b0;
          end
        end
        FLUSH: begin
          state      <= DONE;
          flush_done <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          flush_done  <= 1'b0;
          alloc_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          flush_done  <= 1'b0;
          alloc_ready <= 1'b1;
        end
      endcase
    end
  end

  // Register 0 is only ever touched by reset, so storage reads for it stay 0/valid/tag 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '1;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = REG_ZERO + 1; i < NUM_REGS; i++) begin
        if (cm_we[i]) data_q[i] <= cm_wdata[i];
        if (state == FLUSH) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= '0;
        end else if (alloc_fire && (alloc_rd == RW'(i))) begin
          valid_q[i] <= 1'b0;
          tag_q[i]   <= alloc_tag;
        end else if (cm_we[i] && cm_match[i]) begin
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [RW-1:0] addr;
    addr     = '0;
    rd_data  = '0;
    rd_valid = '0;
    rd_tag   = '0;
    for (int unsigned q = 0; q < NUM_READ; q++) begin
      addr = rd_addr[q*RW +: RW];
      rd_tag[q*TAG_W +: TAG_W] = tag_q[addr];
      if (cm_we[addr]) begin
        rd_data[q*XLEN +: XLEN] = cm_wdata[addr];
        rd_valid[q]             = cm_match[addr];
      end else begin
        rd_data[q*XLEN +: XLEN] = data_q[addr];
        rd_valid[q]             = valid_q[addr];
      end
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int unsigned i = REG_ZERO + 1; i < NUM_REGS; i++) begin
      pending_cnt = pending_cnt + (RW+1)'(!valid_q[i]);
    end
  end

endmodule

// File: tb/tb_regfile_rat.sv
// Directed bench for regfile_rat: rename, commit bypass, priority and flush handshake.
module tb_regfile_rat;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [2:0]  alloc_tag;
  logic        alloc_ready;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_rd;
  logic [5:0]  cm_tag;
  logic [63:0] cm_data;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_valid;
  logic [8:0]  rd_tag;
  logic        flush_req;
  logic        flush_done;
  logic [5:0]  pending_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_rat #(
    .NUM_REGS(32), .XLEN(32), .TAG_W(3), .NUM_READ(3), .NUM_COMMIT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .alloc_ready(alloc_ready),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .flush_req(flush_req), .flush_done(flush_done), .pending_cnt(pending_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_rd = '0; alloc_tag = '0;
    cm_valid = '0; cm_rd = '0; cm_tag = '0; cm_data = '0;
    flush_req = 1'b0;
  endtask

  task automatic set_cm(input int p, input logic [4:0] rd, input logic [2:0] tag,
                        input logic [31:0] d);
    cm_valid[p]       = 1'b1;
    cm_rd[p*5 +: 5]   = rd;
    cm_tag[p*3 +: 3]  = tag;
    cm_data[p*32 +: 32] = d;
  endtask

  task automatic set_alloc(input logic [4:0] rd, input logic [2:0] tag);
    alloc_valid = 1'b1; alloc_rd = rd; alloc_tag = tag;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    rd_addr = {5'd5, 5'd5, 5'd5};
    #12;
    rst = 1'b1;
    tick();
    n_cmp++; if (rd_data !== 96'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", rd_data); end
    n_cmp++; if (rd_valid !== 3'b111) begin n_bad++; $display("FAIL reset_valid: got %b want 111", rd_valid); end
    n_cmp++; if (rd_tag !== 9'h0) begin n_bad++; $display("FAIL reset_tag: got %h want 0", rd_tag); end
    n_cmp++; if (pending_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_pending: got %0d want 0", pending_cnt); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
    n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
  endtask

  task automatic test_alloc_commit();
    set_alloc(5'd5, 3'd3);
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (pending_cnt !== 6'd1) begin n_bad++; $display("FAIL alloc_pending: got %0d want 1", pending_cnt); end
    n_cmp++; if (rd_valid[0] !== 1'b0 || rd_tag[2:0] !== 3'd3) begin n_bad++; $display("FAIL alloc_read: got v%b t%0d want v0 t3", rd_valid[0], rd_tag[2:0]); end
    set_cm(0, 5'd5, 3'd3, 32'hDEADBEEF);
    #1;
    n_cmp++; if (rd_data[63:32] !== 32'hDEADBEEF || rd_valid[1] !== 1'b1) begin n_bad++; $display("FAIL bypass_r5: got %h v%b want deadbeef v1", rd_data[63:32], rd_valid[1]); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_valid[0] !== 1'b1) begin n_bad++; $display("FAIL commit_r5: got %h v%b want deadbeef v1", rd_data[31:0], rd_valid[0]); end
    n_cmp++; if (pending_cnt !== 6'd0) begin n_bad++; $display("FAIL commit_pending: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_stale_commit();
    rd_addr = {5'd7, 5'd7, 5'd7};
    set_alloc(5'd7, 3'd2);
    tick();
    set_alloc(5'd7, 3'd4);
    tick();
    idle_inputs();
    set_cm(0, 5'd7, 3'd2, 32'h11);
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h11 || rd_valid[0] !== 1'b0) begin n_bad++; $display("FAIL stale_bypass: got %h v%b want 11 v0", rd_data[31:0], rd_valid[0]); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h11 || rd_valid[0] !== 1'b0 || rd_tag[2:0] !== 3'd4) begin n_bad++; $display("FAIL stale_store: got %h v%b t%0d want 11 v0 t4", rd_data[31:0], rd_valid[0], rd_tag[2:0]); end
    n_cmp++; if (pending_cnt !== 6'd1) begin n_bad++; $display("FAIL stale_pending: got %0d want 1", pending_cnt); end
  endtask

  task automatic test_alloc_commit_same();
    rd_addr = {5'd9, 5'd9, 5'd9};
    set_alloc(5'd9, 3'd6);
    set_cm(1, 5'd9, 3'd0, 32'h22);
    #1;
    n_cmp++; if (rd_data[95:64] !== 32'h22 || rd_valid[2] !== 1'b1 || rd_tag[8:6] !== 3'd0) begin n_bad++; $display("FAIL same_bypass: got %h v%b t%0d want 22 v1 t0", rd_data[95:64], rd_valid[2], rd_tag[8:6]); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h22 || rd_valid[0] !== 1'b0 || rd_tag[2:0] !== 3'd6) begin n_bad++; $display("FAIL same_store: got %h v%b t%0d want 22 v0 t6", rd_data[31:0], rd_valid[0], rd_tag[2:0]); end
    n_cmp++; if (pending_cnt !== 6'd2) begin n_bad++; $display("FAIL same_pending: got %0d want 2", pending_cnt); end
  endtask

  task automatic test_dual_commit();
    rd_addr = {5'd3, 5'd3, 5'd3};
    set_cm(0, 5'd3, 3'd5, 32'hAA);
    set_cm(1, 5'd3, 3'd0, 32'hBB);
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hBB || rd_valid[0] !== 1'b1) begin n_bad++; $display("FAIL dual_bypass: got %h v%b want bb v1", rd_data[31:0], rd_valid[0]); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hBB || rd_valid[0] !== 1'b1) begin n_bad++; $display("FAIL dual_store: got %h v%b want bb v1", rd_data[31:0], rd_valid[0]); end
    // reversed: older port matches, younger does not -> younger decides
    set_alloc(5'd3, 3'd1);
    tick();
    idle_inputs();
    set_cm(0, 5'd3, 3'd1, 32'hAA);
    set_cm(1, 5'd3, 3'd5, 32'hBB);
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hBB || rd_valid[0] !== 1'b0) begin n_bad++; $display("FAIL dual2_bypass: got %h v%b want bb v0", rd_data[31:0], rd_valid[0]); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hBB || rd_valid[0] !== 1'b0 || rd_tag[2:0] !== 3'd1) begin n_bad++; $display("FAIL dual2_store: got %h v%b t%0d want bb v0 t1", rd_data[31:0], rd_valid[0], rd_tag[2:0]); end
    n_cmp++; if (pending_cnt !== 6'd3) begin n_bad++; $display("FAIL dual_pending: got %0d want 3", pending_cnt); end
  endtask

  task automatic test_reg_zero();
    rd_addr = {5'd0, 5'd0, 5'd0};
    set_alloc(5'd0, 3'd5);
    set_cm(0, 5'd0, 3'd0, 32'h55);
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0 || rd_valid[0] !== 1'b1 || rd_tag[2:0] !== 3'd0) begin n_bad++; $display("FAIL r0_bypass: got %h v%b t%0d want 0 v1 t0", rd_data[31:0], rd_valid[0], rd_tag[2:0]); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0 || rd_valid[0] !== 1'b1 || rd_tag[2:0] !== 3'd0) begin n_bad++; $display("FAIL r0_store: got %h v%b t%0d want 0 v1 t0", rd_data[31:0], rd_valid[0], rd_tag[2:0]); end
    n_cmp++; if (pending_cnt !== 6'd3) begin n_bad++; $display("FAIL r0_pending: got %0d want 3", pending_cnt); end
  endtask

  task automatic test_flush();
    set_alloc(5'd1, 3'd1); tick();
    set_alloc(5'd2, 3'd2); tick();
    set_alloc(5'd4, 3'd3); tick();
    idle_inputs();
    #1;
    n_cmp++; if (pending_cnt !== 6'd6) begin n_bad++; $display("FAIL preflush_pending: got %0d want 6", pending_cnt); end
    flush_req = 1'b1;                       // cycle n
    tick();                                 // n+1: FLUSH
    flush_req = 1'b0;
    set_alloc(5'd10, 3'd7);
    set_cm(0, 5'd11, 3'd0, 32'h77);
    #1;
    n_cmp++; if (alloc_ready !== 1'b0 || flush_done !== 1'b0) begin n_bad++; $display("FAIL flush_n1: got ar%b fd%b want ar0 fd0", alloc_ready, flush_done); end
    tick();                                 // n+2: DONE
    idle_inputs();
    flush_req = 1'b1;
    rd_addr = {5'd1, 5'd11, 5'd10};
    #1;
    n_cmp++; if (alloc_ready !== 1'b0 || flush_done !== 1'b1) begin n_bad++; $display("FAIL flush_n2: got ar%b fd%b want ar0 fd1", alloc_ready, flush_done); end
    n_cmp++; if (pending_cnt !== 6'd0) begin n_bad++; $display("FAIL flush_pending: got %0d want 0", pending_cnt); end
    n_cmp++; if (rd_valid !== 3'b111 || rd_tag !== 9'h0) begin n_bad++; $display("FAIL flush_restore: got v%b t%h want v111 t0", rd_valid, rd_tag); end
    n_cmp++; if (rd_data[63:32] !== 32'h77) begin n_bad++; $display("FAIL flush_commit_data: got %h want 77", rd_data[63:32]); end
    tick();                                 // n+3: IDLE, flush_req in DONE ignored
    idle_inputs();
    set_alloc(5'd12, 3'd2);
    #1;
    n_cmp++; if (alloc_ready !== 1'b1 || flush_done !== 1'b0) begin n_bad++; $display("FAIL flush_n3: got ar%b fd%b want ar1 fd0", alloc_ready, flush_done); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (pending_cnt !== 6'd1 || alloc_ready !== 1'b1) begin n_bad++; $display("FAIL post_flush_alloc: got p%0d ar%b want p1 ar1", pending_cnt, alloc_ready); end
  endtask

  task automatic test_flush_reset();
    int pulses;
    pulses = 0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL rflush_n1: got ar%b want ar0", alloc_ready); end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (alloc_ready !== 1'b1 || flush_done !== 1'b0 || pending_cnt !== 6'd0) begin n_bad++; $display("FAIL rflush_async: got ar%b fd%b p%0d want ar1 fd0 p0", alloc_ready, flush_done, pending_cnt); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_bad++; $display("FAIL rflush_data: got %h want 0", rd_data[63:32]); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (flush_done !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses !== 0 || alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rflush_no_done: got pulses %0d ar%b want 0 ar1", pulses, alloc_ready); end
  endtask

  initial begin
    test_reset();
    test_alloc_commit();
    test_stale_commit();
    test_alloc_commit_same();
    test_dual_commit();
    test_reg_zero();
    test_flush();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
